// File: rtl/camera_pwr_seq_pkg.sv
// Shared types and helpers for the camera power-rail sequencer.
package camera_pwr_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_UP_PG  = 3'd1,
    ST_UP_DLY = 3'd2,
    ST_ON     = 3'd3,
    ST_DN_DLY = 3'd4,
    ST_FAULT  = 3'd5
  } pwr_state_e;

  localparam int unsigned PG_TIMEOUT_CYC_DEF = 1000000;

  function automatic int step_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pwr_seq_timer.sv
// Saturating up-counter shared by the power-good timeout and the step delays.
module pwr_seq_timer #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] target_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign done_o = (cnt_q >= target_i);

endmodule

// File: rtl/camera_power_sequencer.sv
// Ordered power-up / reverse power-down of NUM_STEPS enables with PG timeout and fault latch.
// Optional in-ON power-good monitoring is enabled with the CAM_PWR_PG_MONITOR_EN macro.
module camera_power_sequencer
  import camera_pwr_seq_pkg::*;
#(
  parameter int          NUM_STEPS      = 5,
  parameter int          CNT_W          = 32,
  parameter int unsigned PG_TIMEOUT_CYC = PG_TIMEOUT_CYC_DEF,
  parameter int          STEP_W         = step_width(NUM_STEPS)
) (
  input  logic                       ctrl_clk_i,
  input  logic                       ctrl_rst_n_i,
  input  logic                       pwr_up_i,
  input  logic                       pwr_dn_i,
  input  logic                       clr_fault_i,
  input  logic [NUM_STEPS*CNT_W-1:0] step_dly_i,
  input  logic [NUM_STEPS-1:0]       pgood_i,
  output logic [NUM_STEPS-1:0]       en_o,
  output logic                       busy_o,
  output logic                       on_o,
  output logic                       fault_o,
  output logic [STEP_W-1:0]          fault_step_o
);

  localparam logic [CNT_W-1:0]  PG_LIMIT  = CNT_W'(PG_TIMEOUT_CYC - 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

  pwr_state_e           state_q, state_d;
  logic [STEP_W-1:0]    step_q, step_d;
  logic [NUM_STEPS-1:0] en_q, en_d;
  logic                 on_q, on_d;
  logic                 fault_q, fault_d;
  logic [STEP_W-1:0]    fstep_q, fstep_d;
  logic                 tmr_clr, tmr_done, busy;
  logic [CNT_W-1:0]     dly_sel, tmr_target;

  always_comb begin
    dly_sel = '0;
    for (int k = 0; k < NUM_STEPS; k++) begin
      if (step_q == STEP_W'(k)) dly_sel = step_dly_i[k*CNT_W +: CNT_W];
    end
  end

  assign busy       = (state_q == ST_UP_PG) || (state_q == ST_UP_DLY) || (state_q == ST_DN_DLY);
  assign tmr_target = (state_q == ST_UP_PG) ? PG_LIMIT : dly_sel;

  pwr_seq_timer #(.CNT_W(CNT_W)) u_timer (
    .clk_i    (ctrl_clk_i),
    .rst_n_i  (ctrl_rst_n_i),
    .clr_i    (tmr_clr),
    .en_i     (busy),
    .target_i (tmr_target),
    .done_o   (tmr_done)
  );

`ifdef CAM_PWR_PG_MONITOR_EN
  // A rail counts as lost only when it reads low on two consecutive ON samples.
  logic [NUM_STEPS-1:0] pg_low_q, pg_fail;
  logic [STEP_W-1:0]    pg_fail_idx;

  assign pg_fail = pg_low_q & ~pgood_i;

  always_comb begin
    pg_fail_idx = '0;
    for (int k = NUM_STEPS - 1; k >= 0; k--) begin
      if (pg_fail[k]) pg_fail_idx = STEP_W'(k);
    end
  end

  always_ff @(posedge ctrl_clk_i or negedge ctrl_rst_n_i) begin
    if (!ctrl_rst_n_i) pg_low_q <= '0;
    else               pg_low_q <= (state_q == ST_ON) ? ~pgood_i : '0;
  end
`endif

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    en_d    = en_q;
    on_d    = on_q;
    fault_d = fault_q;
    fstep_d = fstep_q;
    tmr_clr = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pwr_up_i && !pwr_dn_i) begin
          step_d  = '0;
          en_d[0] = 1'b1;
          tmr_clr = 1'b1;
          state_d = ST_UP_PG;
        end
      end
      ST_UP_PG: begin
        if (pwr_dn_i) begin
          en_d[step_q] = 1'b0;
          tmr_clr      = 1'b1;
          state_d      = ST_DN_DLY;
        end else if (pgood_i[step_q]) begin
          tmr_clr = 1'b1;
          state_d = ST_UP_DLY;
        end else if (tmr_done) begin
          en_d    = '0;
          fault_d = 1'b1;
          fstep_d = step_q;
          state_d = ST_FAULT;
        end
      end
      ST_UP_DLY: begin
        if (pwr_dn_i) begin
          en_d[step_q] = 1'b0;
          tmr_clr      = 1'b1;
          state_d      = ST_DN_DLY;
        end else if (tmr_done) begin
          if (step_q == LAST_STEP) begin
            on_d    = 1'b1;
            state_d = ST_ON;
          end else begin
            step_d       = step_q + STEP_W'(1);
            en_d[step_d] = 1'b1;
            tmr_clr      = 1'b1;
            state_d      = ST_UP_PG;
          end
        end
      end
      ST_ON: begin
        if (pwr_dn_i) begin
          en_d[NUM_STEPS-1] = 1'b0;
          on_d              = 1'b0;
          tmr_clr           = 1'b1;
          state_d           = ST_DN_DLY;
        end
`ifdef CAM_PWR_PG_MONITOR_EN
        else if (|pg_fail) begin
          en_d    = '0;
          on_d    = 1'b0;
          fault_d = 1'b1;
          fstep_d = pg_fail_idx;
          state_d = ST_FAULT;
        end
`endif
      end
      ST_DN_DLY: begin
        if (tmr_done) begin
          if (step_q != '0) begin
            step_d       = step_q - STEP_W'(1);
            en_d[step_d] = 1'b0;
            tmr_clr      = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_FAULT: begin
        if (clr_fault_i) begin
          fault_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ctrl_clk_i or negedge ctrl_rst_n_i) begin
    if (!ctrl_rst_n_i) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      en_q    <= '0;
      on_q    <= 1'b0;
      fault_q <= 1'b0;
      fstep_q <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      en_q    <= en_d;
      on_q    <= on_d;
      fault_q <= fault_d;
      fstep_q <= fstep_d;
    end
  end

  assign en_o         = en_q;
  assign busy_o       = busy;
  assign on_o         = on_q;
  assign fault_o      = fault_q;
  assign fault_step_o = fstep_q;

endmodule

// File: doc/camera_power_sequencer.md
Name: camera_power_sequencer

Overview:
Parametrised power-rail sequencer for the camera sensor front end. It generalises the fixed rail / INCK_EN / XCLR bring-up to NUM_STEPS ordered enable outputs. Each step has a run-time delay and a per-step power-good check with timeout. It also adds a reverse-order power-down, abort, and a fault shutdown. It sits in the Nios II subsystem, driven by a CSR block, and its outputs go to the regulator enables, the INCK gate and XCLR.

Parameters:
NUM_STEPS, 5, number of sequenced enables; bit 0 comes up first and goes down last.
CNT_W, 32, width of each step delay and of the internal timer.
PG_TIMEOUT_CYC, 1000000, cycles allowed for pgood_i[k] to rise after en_o[k] rises.
STEP_W, $clog2(NUM_STEPS) with a minimum of 1, width of the step index.

Ports:
ctrl_clk_i  in  1  control clock
ctrl_rst_n_i  in  1  reset
pwr_up_i  in  1  single-cycle request to start power-up
pwr_dn_i  in  1  single-cycle request to start power-down or abort
clr_fault_i  in  1  clears a latched fault
step_dly_i  in  NUM_STEPS*CNT_W  delay after step k, in slice [k*CNT_W +: CNT_W]; held stable by software while busy_o=1
pgood_i  in  NUM_STEPS  power-good per step; tie unused bits to 1
en_o  out  NUM_STEPS  registered enables, thermometer-coded
busy_o  out  1  high while ramping up or down
on_o  out  1  high when all steps are up
fault_o  out  1  sticky fault flag
fault_step_o  out  STEP_W  index of the step that faulted

Interface (already decided):
One clock; reset is asynchronous and active-low. Clock port is ctrl_clk_i, reset port is ctrl_rst_n_i.

Behaviour:
- Reset: all outputs are 0, the FSM is in IDLE, the timer is 0. Reset asserted mid-sequence drops all en_o immediately, asynchronously.
- States: IDLE, UP_PG, UP_DLY, ON, DN_DLY, FAULT.
- IDLE:
  - pwr_up_i=1 gives step=0 and UP_PG; en_o[0] rises on the next edge.
  - pwr_dn_i in IDLE is ignored.
- UP_PG:
  - The PG timer counts from the first cycle en_o[step] is high.
  - If pgood_i[step] is sampled 1, load the timer with step_dly[step] and go to UP_DLY.
  - If the timer reaches PG_TIMEOUT_CYC first, go to FAULT.
- UP_DLY:
  - When the timer has counted step_dly[step] cycles (0 means advance on the next edge), either:
    - if step < NUM_STEPS-1: increment step, assert en_o[step], go to UP_PG;
    - otherwise go to ON.
  - With pgood already high, consecutive en_o rises are step_dly+2 cycles apart.
- ON: on_o=1 and busy_o=0. pwr_dn_i clears en_o[NUM_STEPS-1], loads the timer with step_dly[NUM_STEPS-1], and goes to DN_DLY.
- DN_DLY:
  - After the timer expires, if step > 0: decrement step, clear en_o[step], reload the timer.
  - If step = 0, go to IDLE. en_o falls are step_dly+1 cycles apart.
  - pgood_i is ignored during power-down.
- Abort: pwr_dn_i in UP_PG or UP_DLY clears the current highest set en_o on the next edge and enters DN_DLY from that step. pwr_dn_i has priority over pwr_up_i in the same cycle. pwr_up_i outside IDLE is ignored.
- FAULT: the next edge clears all en_o simultaneously, sets fault_o=1 and fault_step_o=step. pwr_up_i is ignored while in FAULT. clr_fault_i returns to IDLE and clears fault_o; fault_step_o holds its value until the next fault.
- busy_o = UP_PG | UP_DLY | DN_DLY. on_o is registered and falls in the same edge that en_o[NUM_STEPS-1] falls.
- The timer saturates and never wraps; compares are unsigned CNT_W-bit. en_o only ever changes one bit per edge, except on FAULT or reset.

Optional Feature:
Macro: CAM_PWR_PG_MONITOR_EN.
- Defined: in ON, any pgood_i bit low for 2 consecutive samples sends the FSM to FAULT, with fault_step_o = the lowest failing index.
- Undefined: pgood_i is only examined in UP_PG, and ON holds regardless of pgood_i.

Decomposition:
- Package camera_pwr_seq_pkg holds:
  - the state encoding localparams;
  - the PG_TIMEOUT_CYC default;
  - a function for the STEP_W computation.
- One sub-module, pwr_seq_timer: CNT_W saturating up-counter with load/clear, enable and a done compare output. It is shared by the PG-timeout and step-delay phases; they are never active at the same time.

Test Plan:
1. Normal bring-up:
   - Stimulus: NUM_STEPS=5, all step_dly=10, pgood_i tied to 1, pwr_up_i pulse.
   - Required: en_o goes 00001→00011→…→11111 with rises 12 cycles apart; on_o rises after the last delay; busy_o=0 in ON.
2. Power-down:
   - Stimulus: from ON, pwr_dn_i pulse.
   - Required: en_o falls 11111→01111→…→00000 at 11-cycle spacing; on_o falls with bit 4; FSM ends in IDLE with busy_o=0.
3. PG timeout:
   - Stimulus: PG_TIMEOUT_CYC=50, pgood_i[2]=0.
   - Required: 50 cycles after en_o[2] rises, en_o=00000, fault_o=1, fault_step_o=2; pwr_up_i ignored; clr_fault_i leads to IDLE with fault_o=0.
4. Abort mid-ramp:
   - Stimulus: pwr_dn_i while en_o=00111 in UP_DLY.
   - Required: 00011 on the next edge, then 00001, then 00000; no further rises.
5. Simultaneous requests and reset:
   - pwr_up_i and pwr_dn_i together in IDLE: stays IDLE.
   - ctrl_rst_n_i low during UP_PG: en_o=0 asynchronously; after release, all outputs 0.
6. Monitor (CAM_PWR_PG_MONITOR_EN defined):
   - In ON, drop pgood_i[1] for 2 cycles: FAULT, en_o=0, fault_step_o=1.
   - Drop it for 1 cycle only: stays in ON.
